lsu_dram_ctrl: RTL and testbench
================================

// Module: lsu_dram_ctrl
// PURPOSE
//  Load/store unit between EX and MEM. Takes the EX result (effective address or ALU value),
//  runs one req/ack DRAM transaction per load/store, and aligns and extends load data.
//  Presents registered rd_addr/wreg/wdata to MEM, and stalls EX while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in WAIT_ACK without dram_ack_i before bus error (>=2)
//  CNT_W           9    timeout counter width, must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-low
//  ex_valid_i      in   1   EX presents a valid instruction this cycle
//  flush_i         in   1   kill the instruction in IDLE or in flight
//  rd_addr_i       in   5   destination register
//  wreg_i          in   1   instruction writes rd
//  wdata_i         in   32  ALU result; effective address for loads/stores
//  store_data_i    in   32  rs2 value for stores
//  opcode_i        in   7   0000011=LOAD, 0100011=STORE, other=pass-through
//  funct3_i        in   3   LB000 LH001 LW010 LBU100 LHU101 / SB000 SH001 SW010
//  dram_req_o      out  1   transaction request, held until ack
//  dram_we_o       out  1   1=store
//  dram_addr_o     out  32  {addr[31:2],2'b00}
//  dram_wdata_o    out  32  lane-replicated store data
//  dram_be_o       out  4   byte enables (store only; 0 for loads)
//  dram_ack_i      in   1   one-cycle completion; dram_rdata_i valid with it
//  dram_rdata_i    in   32  read word
//  stall_o         out  1   EX must hold; =(state==WAIT_ACK), combinational from state
//  valid_o         out  1   result valid to MEM, one-cycle pulse per retired instruction
//  rd_addr_o       out  5   to MEM
//  wreg_o          out  1   to MEM; 0 for stores, errors, killed ops
//  wdata_o         out  32  to MEM
//  misalign_o      out  1   pulse with valid_o: misaligned access, no DRAM traffic
//  bus_err_o       out  1   pulse with valid_o: ack timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE. All outputs and registers are 0. dram_req_o drops immediately,
//   and an in-flight transaction is abandoned.
//  FSM IDLE:
//   - ex_valid_i=0 or flush_i=1: nothing is accepted; valid_o=0 next cycle.
//   - Non-memory opcode: register rd/wreg/wdata; valid_o=1 next cycle (latency 1).
//   - Misaligned memory op (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0; funct3 011/110/111 treated
//     as misaligned): no request; next cycle valid_o=1, misalign_o=1, wreg_o=0.
//   - Aligned memory op: capture rd, wreg, funct3, addr[1:0], store data, we; go WAIT_ACK.
//  WAIT_ACK:
//   - dram_req_o=1, and all dram_* outputs stay stable until ack. ex_valid_i is ignored.
//   - dram_ack_i=1: register the result and go IDLE; valid_o=1 next cycle, the same cycle
//     stall_o falls.
//   - Timeout counter resets on entry and increments each cycle without ack. When it reaches
//     TIMEOUT_CYCLES-1 without ack: go IDLE, req drops, next cycle valid_o=1, bus_err_o=1,
//     wreg_o=0. An ack arriving on the timeout cycle wins.
//   - flush_i in WAIT_ACK sets a kill flag; the transaction still completes, but valid_o and
//     wreg_o stay 0. flush_i and ack in the same cycle also count as killed.
//  Load data: sh=addr[1:0]*8.
//   - LB/LBU: rdata[sh+:8], sign/zero-extended.
//   - LH/LHU: rdata[addr[1]*16+:16], sign/zero-extended.
//   - LW: rdata.
//  Store lanes:
//   - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
//   - SH: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011.
//   - SW: d, be=4'b1111.
//   - Stores retire with wreg_o=0 and wdata_o=address.
//  Throughput: 1 instr/cycle for non-memory ops. A memory op costs 1 issue cycle, N wait cycles
//   until ack, then 1 output cycle. Back-to-back memory ops are allowed; the next op is accepted
//   in the cycle stall_o is low.
//  Outputs are held at their last value when valid_o=0, except valid_o, misalign_o and
//   bus_err_o, which return to 0.
// TESTING
//  1 ADD, rd=5, wdata=0x1234 -> next cycle valid_o=1, wreg_o=1, rd_addr_o=5, wdata_o=0x1234,
//    stall_o never high.
//  2 LB addr=0x103, ack after 3 cycles with rdata=0x80FF_0000 -> dram_addr=0x100, stall 3 cycles,
//    wdata_o=0xFFFF_FF80; same case as LBU -> 0x0000_0080.
//  3 SH addr=0x202, data=0xABCD -> we=1, be=4'b1100, dram_wdata=0xABCD_ABCD, wreg_o=0.
//  4 LW addr=0x101 -> no dram_req_o; next cycle misalign_o=1, valid_o=1, wreg_o=0.
//  5 LW with no ack (TIMEOUT_CYCLES=8) -> req drops after 8 cycles, bus_err_o pulse, stall_o
//    falls; an ack arriving on the timeout cycle is taken as success.
//  6 flush_i mid-WAIT_ACK -> ack completes with valid_o=0. rst low mid-transaction ->
//    dram_req_o=0 at once, all outputs 0.

Source files
------------

// File: rtl/lsu_dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dram_ctrl
//  Purpose  : Load/store unit sitting between EX and MEM. Issues one req/ack
//             DRAM transaction per aligned load/store, aligns and extends
//             load data, lane-replicates store data, and presents registered
//             results (rd_addr_o/wreg_o/wdata_o) to MEM. Stalls EX while a
//             transaction is outstanding; times out missing acks.
//  Ports    : clk, rst (async, active-low)
//             EX side  : ex_valid_i, flush_i, rd_addr_i, wreg_i, wdata_i,
//                        store_data_i, opcode_i, funct3_i, stall_o
//             DRAM side: dram_req_o, dram_we_o, dram_addr_o, dram_wdata_o,
//                        dram_be_o, dram_ack_i, dram_rdata_i
//             MEM side : valid_o, rd_addr_o, wreg_o, wdata_o, misalign_o,
//                        bus_err_o
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_dram_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        flush_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] store_data_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  output logic        dram_req_o,
  output logic        dram_we_o,
  output logic [31:0] dram_addr_o,
  output logic [31:0] dram_wdata_o,
  output logic [3:0]  dram_be_o,
  input  logic        dram_ack_i,
  input  logic [31:0] dram_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [4:0]  rd_addr_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [6:0]       C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0]       C_OP_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // FSM and transaction context
  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               kill_q,   kill_d;
  logic [4:0]         rd_q,     rd_d;
  logic               mwreg_q,  mwreg_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [31:0]        addr_q,   addr_d;
  logic               we_q,     we_d;
  logic [31:0]        swdata_q, swdata_d;
  logic [3:0]         be_q,     be_d;

  // Registered MEM-side outputs
  logic               valid_q,    valid_d;
  logic [4:0]         rd_out_q,   rd_out_d;
  logic               wreg_out_q, wreg_out_d;
  logic [31:0]        wdata_out_q, wdata_out_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q,  bus_err_d;

  // Decode of the instruction presented by EX
  logic        w_is_load, w_is_store, w_is_mem;
  logic        w_misalign;
  logic [31:0] w_lane_data;
  logic [3:0]  w_lane_be;

  // Load alignment of the returning word
  logic [31:0] w_rdata_shift;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_kill_now;

  always_comb begin
    w_is_load  = (opcode_i == C_OP_LOAD);
    w_is_store = (opcode_i == C_OP_STORE);
    w_is_mem   = w_is_load | w_is_store;

    // funct3[1:0] encodes size; 11 is never legal, and bit 2 (unsigned) is
    // only legal for byte/half loads. Illegal encodings retire as misaligned.
    w_misalign = (funct3_i[1:0] == 2'b11)
               | (funct3_i[2] & (w_is_store | funct3_i[1]))
               | ((funct3_i[1:0] == 2'b01) & wdata_i[0])
               | ((funct3_i[1:0] == 2'b10) & (wdata_i[1:0] != 2'b00));

    w_lane_data = 32'd0;
    w_lane_be   = 4'b0000;
    if (w_is_store) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_lane_data = {4{store_data_i[7:0]}};
          w_lane_be   = 4'b0001 << wdata_i[1:0];
        end
        2'b01: begin
          w_lane_data = {2{store_data_i[15:0]}};
          w_lane_be   = wdata_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_lane_data = store_data_i;
          w_lane_be   = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata_shift = dram_rdata_i >> {addr_q[1:0], 3'b000};
    w_ld_byte     = w_rdata_shift[7:0];
    w_ld_half     = addr_q[1] ? dram_rdata_i[31:16] : dram_rdata_i[15:0];
    case (funct3_q)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = dram_rdata_i;
    endcase
    // A flush arriving together with the ack still kills the result.
    w_kill_now = kill_q | flush_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    rd_d        = rd_q;
    mwreg_d     = mwreg_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    we_d        = we_q;
    swdata_d    = swdata_q;
    be_d        = be_q;
    valid_d     = 1'b0;
    rd_out_d    = rd_out_q;
    wreg_out_d  = wreg_out_q;
    wdata_out_d = wdata_out_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid_i && !flush_i) begin
          if (!w_is_mem) begin
            valid_d     = 1'b1;
            rd_out_d    = rd_addr_i;
            wreg_out_d  = wreg_i;
            wdata_out_d = wdata_i;
          end else if (w_misalign) begin
            valid_d     = 1'b1;
            misalign_d  = 1'b1;
            rd_out_d    = rd_addr_i;
            wreg_out_d  = 1'b0;
            wdata_out_d = wdata_i;
          end else begin
            state_d  = WAIT_ACK;
            cnt_d    = '0;
            kill_d   = 1'b0;
            rd_d     = rd_addr_i;
            mwreg_d  = wreg_i & w_is_load;
            funct3_d = funct3_i;
            addr_d   = wdata_i;
            we_d     = w_is_store;
            swdata_d = w_lane_data;
            be_d     = w_lane_be;
          end
        end
      end
      WAIT_ACK: begin
        if (dram_ack_i) begin
          state_d = IDLE;
          if (!w_kill_now) begin
            valid_d     = 1'b1;
            rd_out_d    = rd_q;
            wreg_out_d  = mwreg_q;
            wdata_out_d = we_q ? addr_q : w_ld_data;
          end else begin
            wreg_out_d  = 1'b0;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          state_d    = IDLE;
          wreg_out_d = 1'b0;
          if (!w_kill_now) begin
            valid_d   = 1'b1;
            bus_err_d = 1'b1;
            rd_out_d  = rd_q;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          kill_d = w_kill_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      rd_q        <= 5'd0;
      mwreg_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      swdata_q    <= 32'd0;
      be_q        <= 4'd0;
      valid_q     <= 1'b0;
      rd_out_q    <= 5'd0;
      wreg_out_q  <= 1'b0;
      wdata_out_q <= 32'd0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      rd_q        <= rd_d;
      mwreg_q     <= mwreg_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      swdata_q    <= swdata_d;
      be_q        <= be_d;
      valid_q     <= valid_d;
      rd_out_q    <= rd_out_d;
      wreg_out_q  <= wreg_out_d;
      wdata_out_q <= wdata_out_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Request follows the state directly so reset drops it without a clock.
  assign dram_req_o   = (state_q == WAIT_ACK);
  assign stall_o      = (state_q == WAIT_ACK);
  assign dram_we_o    = we_q;
  assign dram_addr_o  = {addr_q[31:2], 2'b00};
  assign dram_wdata_o = swdata_q;
  assign dram_be_o    = be_q;
  assign valid_o      = valid_q;
  assign rd_addr_o    = rd_out_q;
  assign wreg_o       = wreg_out_q;
  assign wdata_o      = wdata_out_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_dram_ctrl
//  Purpose  : Self-checking bench for lsu_dram_ctrl: directed cases followed
//             by randomized instruction mix, checked against a byte-level
//             reference model of the load/store rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dram_ctrl;

  localparam int T = 8;
  localparam logic [6:0] C_LOAD  = 7'b0000011;
  localparam logic [6:0] C_STORE = 7'b0100011;
  localparam logic [6:0] C_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0, flush_i = 1'b0, wreg_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [31:0] wdata_i = '0, store_data_i = '0, dram_rdata_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        dram_ack_i = 1'b0;
  logic        dram_req_o, dram_we_o, stall_o, valid_o, wreg_o, misalign_o, bus_err_o;
  logic [31:0] dram_addr_o, dram_wdata_o, wdata_o;
  logic [3:0]  dram_be_o;
  logic [4:0]  rd_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_dram_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .flush_i(flush_i), .rd_addr_i(rd_addr_i),
    .wreg_i(wreg_i), .wdata_i(wdata_i), .store_data_i(store_data_i),
    .opcode_i(opcode_i), .funct3_i(funct3_i),
    .dram_req_o(dram_req_o), .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_be_o(dram_be_o),
    .dram_ack_i(dram_ack_i), .dram_rdata_i(dram_rdata_i),
    .stall_o(stall_o), .valid_o(valid_o), .rd_addr_o(rd_addr_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int unsigned ref_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_misalign(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % ref_bytes(f3)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned nb, off;
    longint unsigned v;
    nb  = ref_bytes(f3);
    off = a % 4;
    v   = (longint'(rd) >> (off * 8)) % (64'd1 << (nb * 8));
    if (!f3[2] && nb < 4 && v >= (64'd1 << (nb * 8 - 1)))
      v = v - (64'd1 << (nb * 8)) + (64'd1 << 32);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned m;
    m = ((1 << ref_bytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_swdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int unsigned nb;
    nb = ref_bytes(f3);
    r  = '0;
    for (int i = 0; i < 4; i++)
      r = r | (((d >> ((i % nb) * 8)) & 32'hFF) << (i * 8));
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_alu(input logic [4:0] rd, input bit wr, input logic [31:0] val);
    ex_valid_i = 1'b1; opcode_i = C_ALU; rd_addr_i = rd; wreg_i = wr; wdata_i = val;
    funct3_i = 3'($urandom);
    step();
    ex_valid_i = 1'b0;
    check("alu_valid", 32'(valid_o), 32'd1);
    check("alu_rd",    32'(rd_addr_o), 32'(rd));
    check("alu_wreg",  32'(wreg_o), 32'(wr));
    check("alu_wdata", wdata_o, val);
    check("alu_stall", 32'(stall_o), 32'd0);
  endtask

  // ack_at: wait cycle (1-based) carrying the ack, 0 = never.
  // flush_at: wait cycle carrying flush_i, 0 = none.
  task automatic do_mem(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input bit wr,
                        input int ack_at, input logic [31:0] rdata, input int flush_at);
    bit killed, got_ack, done;
    logic [31:0] exp_wd;
    ex_valid_i = 1'b1; opcode_i = st ? C_STORE : C_LOAD; funct3_i = f3;
    wdata_i = a; store_data_i = sd; rd_addr_i = rd; wreg_i = wr;
    step();
    ex_valid_i = 1'b0;
    if (ref_misalign(st, f3, a)) begin
      check("mis_valid", 32'(valid_o), 32'd1);
      check("mis_flag",  32'(misalign_o), 32'd1);
      check("mis_wreg",  32'(wreg_o), 32'd0);
      check("mis_req",   32'(dram_req_o), 32'd0);
      return;
    end
    check("issue_stall", 32'(stall_o), 32'd1);
    check("issue_req",   32'(dram_req_o), 32'd1);
    check("issue_addr",  dram_addr_o, a & 32'hFFFF_FFFC);
    check("issue_we",    32'(dram_we_o), 32'(st));
    check("issue_be",    32'(dram_be_o), st ? 32'(ref_be(f3, a)) : 32'd0);
    if (st) check("issue_swd", dram_wdata_o, ref_swdata(f3, sd));
    killed = 1'b0; got_ack = 1'b0; done = 1'b0;
    for (int i = 1; i <= T && !done; i++) begin
      dram_ack_i   = (i == ack_at);
      flush_i      = (i == flush_at);
      dram_rdata_i = (i == ack_at) ? rdata : $urandom;
      // EX traffic while stalled must be ignored
      ex_valid_i = 1'b1; opcode_i = C_ALU; rd_addr_i = 5'($urandom); wdata_i = $urandom;
      if (i == flush_at) killed = 1'b1;
      step();
      got_ack = (i == ack_at);
      dram_ack_i = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0;
      if (got_ack || i == T) begin
        done = 1'b1;
      end else begin
        check("wait_stall", 32'(stall_o), 32'd1);
        check("wait_valid", 32'(valid_o), 32'd0);
        check("wait_addr",  dram_addr_o, a & 32'hFFFF_FFFC);
      end
    end
    check("done_stall", 32'(stall_o), 32'd0);
    check("done_req",   32'(dram_req_o), 32'd0);
    check("done_valid", 32'(valid_o), 32'(!killed));
    check("done_berr",  32'(bus_err_o), 32'(!killed && !got_ack));
    check("done_mis",   32'(misalign_o), 32'd0);
    check("done_wreg",  32'(wreg_o), 32'(!killed && got_ack && !st && wr));
    if (!killed) begin
      check("done_rd", 32'(rd_addr_o), 32'(rd));
      if (got_ack) begin
        exp_wd = st ? a : ref_load(f3, a, rdata);
        check("done_wdata", wdata_o, exp_wd);
      end
    end
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] a;

    // Reset state
    step(); step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_req",   32'(dram_req_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_rd",    32'(rd_addr_o), 32'd0);
    rst = 1'b1;
    step();

    // 1: ALU pass-through, then output holds with valid_o low
    do_alu(5'd5, 1'b1, 32'h1234);
    step();
    check("hold_valid", 32'(valid_o), 32'd0);
    check("hold_rd",    32'(rd_addr_o), 32'd5);
    check("hold_wdata", wdata_o, 32'h1234);

    // flush in IDLE: nothing accepted
    ex_valid_i = 1'b1; flush_i = 1'b1; opcode_i = C_ALU; rd_addr_i = 5'd9;
    step();
    ex_valid_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_valid", 32'(valid_o), 32'd0);

    // 2: LB / LBU at 0x103, ack on the third wait cycle
    do_mem(1'b0, 3'b000, 32'h103, 32'd0, 5'd7, 1'b1, 3, 32'h80FF_0000, 0);
    check("t2_lb", wdata_o, 32'hFFFF_FF80);
    do_mem(1'b0, 3'b100, 32'h103, 32'd0, 5'd7, 1'b1, 3, 32'h80FF_0000, 0);
    check("t2_lbu", wdata_o, 32'h0000_0080);

    // 3: SH at 0x202
    do_mem(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd3, 1'b1, 2, 32'd0, 0);
    check("t3_be",    32'(dram_be_o), 32'hC);
    check("t3_wdata", dram_wdata_o, 32'hABCD_ABCD);

    // 4: misaligned LW
    do_mem(1'b0, 3'b010, 32'h101, 32'd0, 5'd4, 1'b1, 1, 32'd0, 0);

    // 5: timeout, then ack on the timeout cycle
    do_mem(1'b0, 3'b010, 32'h400, 32'd0, 5'd8, 1'b1, 0, 32'd0, 0);
    do_mem(1'b0, 3'b010, 32'h404, 32'd0, 5'd8, 1'b1, T, 32'hDEAD_BEEF, 0);

    // 6: flush mid-transaction, and flush coincident with ack
    do_mem(1'b0, 3'b010, 32'h500, 32'd0, 5'd2, 1'b1, 4, 32'h1111_2222, 2);
    do_mem(1'b0, 3'b001, 32'h502, 32'd0, 5'd2, 1'b1, 3, 32'h1111_2222, 3);

    // back-to-back: memory op immediately followed by ALU op
    do_mem(1'b0, 3'b101, 32'h606, 32'd0, 5'd11, 1'b1, 1, 32'h8001_7FFF, 0);
    do_alu(5'd12, 1'b1, 32'hCAFE_F00D);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      if ($urandom % 4 == 0) begin
        do_alu(5'($urandom), 1'($urandom), $urandom);
      end else begin
        st = 1'($urandom);
        f3 = st ? 3'($urandom % 4) : 3'($urandom);
        a  = $urandom;
        if ($urandom % 4 != 0) a = a - (a % ref_bytes(f3));
        do_mem(st, f3, a, $urandom, 5'($urandom), 1'($urandom),
               int'($urandom_range(1, 10)), $urandom,
               ($urandom % 6 == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    // Asynchronous reset during an outstanding transaction
    ex_valid_i = 1'b1; opcode_i = C_LOAD; funct3_i = 3'b010; wdata_i = 32'h700;
    rd_addr_i = 5'd13; wreg_i = 1'b1;
    step();
    ex_valid_i = 1'b0;
    step();
    check("pre_rst_req", 32'(dram_req_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_req",   32'(dram_req_o), 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_addr",  dram_addr_o, 32'd0);
    check("arst_wdata", wdata_o, 32'd0);
    check("arst_rd",    32'(rd_addr_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    step();
    rst = 1'b1;
    step();
    do_alu(5'd31, 1'b0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
